// File: rtl/mp_add_seq.sv
// mp_add_seq: multi-precision add sequencer built around one adder_8.
// Two NBYTES-wide operands are accepted on a valid/ready input port.
// They are summed one byte per cycle, least-significant byte first.
// The byte carry is registered and chained into the next byte.
// The wide sum and the final carry come out on a valid/ready output port.
//
// Optional feature macro: MP_ADD_SUB_EN. When it is defined, sub=1 at
// accept computes a - b: B is inverted and the carry is forced to 1.
// When it is undefined, sub is ignored and the block always adds.
//
// Handshake semantics, for both ports: a transfer happens on a rising
// edge where valid and ready are both high. A source holds its payload
// stable while valid is high and ready is low. in_ready and out_valid
// are registered and depend on FSM state only. There is no
// combinational path from in_valid to in_ready, or from out_ready to
// out_valid.

// 8-bit adder with carry in and carry out: the only carry chain in the block.
module adder_8 (
   input  logic [7:0] in1,
   input  logic [7:0] in2,
   input  logic       cin,
   output logic [7:0] sum,
   output logic       cout
);

   // Single-byte add producing a 9-bit {carry, sum}.
   always_comb begin
      {cout, sum} = {1'b0, in1} + {1'b0, in2} + {8'd0, cin};
   end

endmodule

module mp_add_seq #(
   parameter int NBYTES = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [8*NBYTES-1:0] a,
   input  logic [8*NBYTES-1:0] b,
   input  logic                cin,
   input  logic                sub,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [8*NBYTES-1:0] sum,
   output logic                cout,
   output logic [1:0]          dbg_state
);

   localparam int W  = 8 * NBYTES;
   localparam int IW = $clog2(NBYTES);
   localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state;
   logic [W-1:0]    a_q;
   logic [W-1:0]    b_q;
   logic [7:0]      res_byte [NBYTES];
   logic [7:0]      a_byte   [NBYTES];
   logic [7:0]      b_byte   [NBYTES];
   logic            carry_q;
   logic [IW-1:0]   idx;
   logic [7:0]      add_sum;
   logic            add_cout;

`ifndef MP_ADD_SUB_EN
   // Without the subtract feature the sub port has no function.
   logic unused_sub;
   assign unused_sub = sub;
`endif

   // Split the operand registers into bytes and pack the result bytes into sum.
   for (genvar g = 0; g < NBYTES; g++) begin : g_bytes
      assign a_byte[g]       = a_q[8*g +: 8];
      assign b_byte[g]       = b_q[8*g +: 8];
      assign sum[8*g +: 8]   = res_byte[g];
   end

   assign cout      = carry_q;
   assign dbg_state = state;

   // The byte selected by idx goes through the single adder, with the registered carry.
   adder_8 u_adder (
      .in1  (a_byte[idx]),
      .in2  (b_byte[idx]),
      .cin  (carry_q),
      .sum  (add_sum),
      .cout (add_cout)
   );

   // Sequencer FSM: accepts in IDLE, processes one byte per cycle in RUN, and presents the result in DONE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         a_q       <= '0;
         b_q       <= '0;
         carry_q   <= 1'b0;
         idx       <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         for (int i = 0; i < NBYTES; i++) res_byte[i] <= 8'd0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  a_q <= a;
`ifdef MP_ADD_SUB_EN
                  // Two's-complement subtract: a + ~b + 1.
                  b_q     <= sub ? ~b : b;
                  carry_q <= sub ? 1'b1 : cin;
`else
                  b_q     <= b;
                  carry_q <= cin;
`endif
                  idx      <= '0;
                  in_ready <= 1'b0;
                  state    <= RUN;
               end
            end
            RUN: begin
               res_byte[idx] <= add_sum;
               carry_q       <= add_cout;
               if (idx == LAST) begin
                  idx       <= '0;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            DONE: begin
               // Result registers hold stable until the downstream side takes them.
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mp_add_seq.sv
// Bench for mp_add_seq (NBYTES=4). It uses directed vectors with hand-computed
// results, plus a random back-to-back stream checked against an expected queue.
module tb_mp_add_seq;

   localparam int NB = 4;
   localparam int W  = 8 * NB;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  a = '0;
   logic [W-1:0]  b = '0;
   logic          cin = 1'b0;
   logic          sub = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [W-1:0]  sum;
   logic          cout;
   logic [1:0]    dbg_state;

   int errors = 0;
   int checks = 0;

   logic [W:0] exp_q[$];

   mp_add_seq #(.NBYTES(NB)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .dbg_state (dbg_state)
   );

   // Clock generation.
   always #5 clk = ~clk;

   // Drive one operation and return at the falling edge just after it is accepted.
   task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic c, input logic s);
      int n;
      n = 0;
      a = av; b = bv; cin = c; sub = s; in_valid = 1'b1;
      while (in_ready !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         checks++; errors++;
         $display("FAIL send_timeout: in_ready got %b required 1", in_ready);
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Count rising edges from accept until out_valid is seen.
   task automatic wait_out(output int cyc);
      cyc = 0;
      while (out_valid !== 1'b1 && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      if (cyc >= 50) begin
         checks++; errors++;
         $display("FAIL out_timeout: out_valid got %b required 1", out_valid);
      end
   endtask

   // Take one result with a single-cycle out_ready pulse.
   task automatic recv();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b required 0", out_valid); end
      checks++; if (sum !== '0) begin errors++; $display("FAIL rst_sum: got %h required 0", sum); end
      checks++; if (cout !== 1'b0) begin errors++; $display("FAIL rst_cout: got %b required 0", cout); end
      rst = 1'b0;
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b required 1", in_ready); end
   endtask

   task automatic test_reset_mid_run();
      int cyc;
      send(32'h12345678, 32'h11111111, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %b required 0", out_valid); end
      checks++; if (sum !== '0) begin errors++; $display("FAIL midrst_sum: got %h required 0", sum); end
      checks++; if (cout !== 1'b0) begin errors++; $display("FAIL midrst_cout: got %b required 0", cout); end
      @(negedge clk);
      rst = 1'b0;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got %b required 1", in_ready); end
      send(32'd1, 32'd2, 1'b0, 1'b0);
      wait_out(cyc);
      checks++; if (sum !== 32'd3) begin errors++; $display("FAIL midrst_new_sum: got %h required 3", sum); end
      checks++; if (cout !== 1'b0) begin errors++; $display("FAIL midrst_new_cout: got %b required 0", cout); end
      recv();
   endtask

   task automatic test_ripple();
      int cyc;
      send(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0);
      wait_out(cyc);
      checks++; if (cyc != NB) begin errors++; $display("FAIL ripple_latency: got %0d required %0d", cyc, NB); end
      checks++; if (sum !== 32'h00000000) begin errors++; $display("FAIL ripple_sum: got %h required 00000000", sum); end
      checks++; if (cout !== 1'b1) begin errors++; $display("FAIL ripple_cout: got %b required 1", cout); end
      recv();
   endtask

   task automatic test_byte_carries();
      int cyc;
      send(32'h00FF00FF, 32'h00010001, 1'b0, 1'b0);
      wait_out(cyc);
      checks++; if (sum !== 32'h01000100) begin errors++; $display("FAIL bytecarry_sum: got %h required 01000100", sum); end
      checks++; if (cout !== 1'b0) begin errors++; $display("FAIL bytecarry_cout: got %b required 0", cout); end
      recv();
      send(32'h80000000, 32'h80000001, 1'b1, 1'b0);
      wait_out(cyc);
      checks++; if (sum !== 32'h00000002) begin errors++; $display("FAIL msbcarry_sum: got %h required 00000002", sum); end
      checks++; if (cout !== 1'b1) begin errors++; $display("FAIL msbcarry_cout: got %b required 1", cout); end
      recv();
   endtask

   task automatic test_backpressure();
      int cyc;
      send(32'h0A0B0C0D, 32'h01010101, 1'b0, 1'b0);
      wait_out(cyc);
      a = 32'hDEADBEEF; b = 32'h12345678; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++; if (sum !== 32'h0B0C0D0E) begin errors++; $display("FAIL bp_sum[%0d]: got %h required 0b0c0d0e", i, sum); end
         checks++; if (cout !== 1'b0) begin errors++; $display("FAIL bp_cout[%0d]: got %b required 0", i, cout); end
         checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b required 0", i, in_ready); end
         checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid[%0d]: got %b required 1", i, out_valid); end
      end
      in_valid = 1'b0;
      recv();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_out_valid: got %b required 0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready: got %b required 1", in_ready); end
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup: got %b required 0", out_valid); end
   endtask

   task automatic test_sub();
      int cyc;
      logic [W-1:0] e_sum;
      logic         e_cout;
      send(32'd5, 32'd7, 1'b0, 1'b1);
      wait_out(cyc);
`ifdef MP_ADD_SUB_EN
      e_sum = 32'hFFFFFFFE; e_cout = 1'b0;
`else
      e_sum = 32'd12; e_cout = 1'b0;
`endif
      checks++; if (sum !== e_sum) begin errors++; $display("FAIL sub_5_7_sum: got %h required %h", sum, e_sum); end
      checks++; if (cout !== e_cout) begin errors++; $display("FAIL sub_5_7_cout: got %b required %b", cout, e_cout); end
      recv();
      send(32'd7, 32'd5, 1'b0, 1'b1);
      wait_out(cyc);
`ifdef MP_ADD_SUB_EN
      e_sum = 32'd2; e_cout = 1'b1;
`else
      e_sum = 32'd12; e_cout = 1'b0;
`endif
      checks++; if (sum !== e_sum) begin errors++; $display("FAIL sub_7_5_sum: got %h required %h", sum, e_sum); end
      checks++; if (cout !== e_cout) begin errors++; $display("FAIL sub_7_5_cout: got %b required %b", cout, e_cout); end
      recv();
      sub = 1'b0;
   endtask

   task automatic test_back_to_back();
      int sent;
      int got;
      int cyc;
      logic [W:0] e;
      sent = 0; got = 0; cyc = 0;
      sub = 1'b0;
      exp_q.delete();
      while ((sent < 1000 || got < 1000) && cyc < 40000) begin
         // Output side: a transfer happens on the next edge if out_valid and out_ready are both high.
         out_ready = ($urandom_range(0, 3) != 0);
         if (out_valid === 1'b1 && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL b2b_extra: got %h with nothing expected", {cout, sum});
            end else begin
               e = exp_q.pop_front();
               checks++;
               if ({cout, sum} !== e) begin
                  errors++;
                  $display("FAIL b2b[%0d]: got %h required %h", got, {cout, sum}, e);
               end
            end
            got++;
         end
         // Input side: an offer made while in_ready is high is taken on the next edge.
         in_valid = (sent < 1000) && ($urandom_range(0, 2) != 0);
         a   = $urandom;
         b   = $urandom;
         cin = 1'($urandom_range(0, 1));
         if (in_valid && in_ready === 1'b1) begin
            exp_q.push_back({1'b0, a} + {1'b0, b} + {32'd0, cin});
            sent++;
         end
         @(negedge clk);
         cyc++;
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      checks++; if (got != 1000) begin errors++; $display("FAIL b2b_count: got %0d required 1000", got); end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_leftover: got %0d required 0", exp_q.size()); end
   endtask

   // Scenario sequence and final report.
   initial begin
      @(negedge clk);
      test_reset();
      test_reset_mid_run();
      test_ripple();
      test_byte_carries();
      test_backpressure();
      test_sub();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
